// File: rtl/aqp_ovl_writer_if.sv
// Command link and overlay write ports of the overlay writer.
// The master modport is the writer's view; the slave modport is the host/overlay side.
interface aqp_ovl_writer_if;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  ovl_text_addr;
  logic [15:0] ovl_text_wrdata;
  logic        ovl_text_wr;
  logic [10:0] ovl_font_addr;
  logic [7:0]  ovl_font_wrdata;
  logic        ovl_font_wr;
  logic [3:0]  ovl_palette_addr;
  logic [15:0] ovl_palette_wrdata;
  logic        ovl_palette_wr;

  modport master (
    input  cmd_data, cmd_valid,
    output cmd_ready,
    output ovl_text_addr, ovl_text_wrdata, ovl_text_wr,
    output ovl_font_addr, ovl_font_wrdata, ovl_font_wr,
    output ovl_palette_addr, ovl_palette_wrdata, ovl_palette_wr
  );

  modport slave (
    output cmd_data, cmd_valid,
    input  cmd_ready,
    input  ovl_text_addr, ovl_text_wrdata, ovl_text_wr,
    input  ovl_font_addr, ovl_font_wrdata, ovl_font_wr,
    input  ovl_palette_addr, ovl_palette_wrdata, ovl_palette_wr
  );
endinterface

// File: rtl/aqp_ovl_writer.sv
// Byte-stream command decoder driving the text/font/palette write ports of the overlay,
// with auto-incrementing text/font pointers and a text-fill engine.
module aqp_ovl_writer #(
  parameter int unsigned FILL_WORDS = 1024  // 1..1024 words cleared by FILL_TEXT
) (
  input  logic              ovl_clk,
  input  logic              ovl_reset_n,
  aqp_ovl_writer_if.master  bus,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_FILL} state_t;

  localparam logic [7:0] OP_SET_TP    = 8'h01;
  localparam logic [7:0] OP_WR_TEXT   = 8'h02;
  localparam logic [7:0] OP_SET_FP    = 8'h03;
  localparam logic [7:0] OP_WR_FONT   = 8'h04;
  localparam logic [7:0] OP_WR_PAL    = 8'h05;
  localparam logic [7:0] OP_FILL_TEXT = 8'h06;

  localparam logic [10:0] FILL_N = 11'(FILL_WORDS);

  // Index of the final argument byte for each opcode (arguments counted from 0).
  function automatic logic [1:0] last_idx(input logic [7:0] op);
    case (op)
      OP_WR_FONT: last_idx = 2'd0;
      OP_WR_PAL:  last_idx = 2'd2;
      default:    last_idx = 2'd1;
    endcase
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    is_known = (op >= OP_SET_TP) && (op <= OP_FILL_TEXT);
  endfunction

  state_t state, state_nxt;

  logic [7:0]  opcode, opcode_d;
  logic [1:0]  arg_idx, arg_idx_d;
  logic [7:0]  b0, b0_d;
  logic [7:0]  b1, b1_d;
  logic [9:0]  tp, tp_d;
  logic [10:0] fp, fp_d;
  logic [10:0] fill_cnt, fill_cnt_d;
  logic [15:0] fill_pat, fill_pat_d;

  logic        text_wr, text_wr_d;
  logic [9:0]  text_addr, text_addr_d;
  logic [15:0] text_data, text_data_d;
  logic        font_wr, font_wr_d;
  logic [10:0] font_addr, font_addr_d;
  logic [7:0]  font_data, font_data_d;
  logic        pal_wr, pal_wr_d;
  logic [3:0]  pal_addr, pal_addr_d;
  logic [15:0] pal_data, pal_data_d;
  logic        err_d;

  logic accept;
  logic last_arg;
  logic fill_done;

  assign bus.cmd_ready = (state != S_FILL);
  assign busy          = (state != S_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign last_arg      = (state == S_ARG) && accept && (arg_idx == last_idx(opcode));
  // fill_cnt counts writes already registered; the last one is on the outputs when it hits FILL_N.
  assign fill_done     = (state == S_FILL) && (fill_cnt == FILL_N);

  // State register.
  // NOTE: sequential logic uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking (=) is reserved for the combinational processes below.
  always_ff @(posedge ovl_clk or negedge ovl_reset_n) begin
    if (!ovl_reset_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_known(bus.cmd_data)) state_nxt = S_ARG;
      S_ARG:  if (last_arg) state_nxt = (opcode == OP_FILL_TEXT) ? S_FILL : S_IDLE;
      S_FILL: if (fill_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything here is registered below.
  always_comb begin
    opcode_d    = opcode;
    arg_idx_d   = arg_idx;
    b0_d        = b0;
    b1_d        = b1;
    tp_d        = tp;
    fp_d        = fp;
    fill_cnt_d  = fill_cnt;
    fill_pat_d  = fill_pat;
    text_wr_d   = 1'b0;
    text_addr_d = text_addr;
    text_data_d = text_data;
    font_wr_d   = 1'b0;
    font_addr_d = font_addr;
    font_data_d = font_data;
    pal_wr_d    = 1'b0;
    pal_addr_d  = pal_addr;
    pal_data_d  = pal_data;
    err_d       = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          opcode_d  = bus.cmd_data;
          arg_idx_d = 2'd0;
          err_d     = !is_known(bus.cmd_data);
        end
      end

      S_ARG: begin
        if (accept) begin
          if (arg_idx == 2'd0) b0_d = bus.cmd_data;
          if (arg_idx == 2'd1) b1_d = bus.cmd_data;
          arg_idx_d = arg_idx + 2'd1;
        end
        // The final byte is used straight from the bus so the write lands one cycle later.
        if (last_arg) begin
          case (opcode)
            OP_SET_TP: tp_d = {bus.cmd_data[1:0], b0};
            OP_WR_TEXT: begin
              text_wr_d   = 1'b1;
              text_addr_d = tp;
              text_data_d = {bus.cmd_data, b0};
              tp_d        = tp + 10'd1;
            end
            OP_SET_FP: fp_d = {bus.cmd_data[2:0], b0};
            OP_WR_FONT: begin
              font_wr_d   = 1'b1;
              font_addr_d = fp;
              font_data_d = bus.cmd_data;
              fp_d        = fp + 11'd1;
            end
            OP_WR_PAL: begin
              pal_wr_d   = 1'b1;
              pal_addr_d = b0[3:0];
              pal_data_d = {bus.cmd_data, b1};
            end
            OP_FILL_TEXT: begin
              fill_pat_d  = {bus.cmd_data, b0};
              text_wr_d   = 1'b1;
              text_addr_d = 10'd0;
              text_data_d = {bus.cmd_data, b0};
              fill_cnt_d  = 11'd1;
            end
            default: ;
          endcase
        end
      end

      S_FILL: begin
        if (fill_done) begin
          tp_d = 10'd0;
        end else begin
          text_wr_d   = 1'b1;
          text_addr_d = fill_cnt[9:0];
          text_data_d = fill_pat;
          fill_cnt_d  = fill_cnt + 11'd1;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge ovl_clk or negedge ovl_reset_n) begin
    if (!ovl_reset_n) begin
      opcode    <= 8'd0;
      arg_idx   <= 2'd0;
      b0        <= 8'd0;
      b1        <= 8'd0;
      tp        <= 10'd0;
      fp        <= 11'd0;
      fill_cnt  <= 11'd0;
      fill_pat  <= 16'd0;
      text_wr   <= 1'b0;
      text_addr <= 10'd0;
      text_data <= 16'd0;
      font_wr   <= 1'b0;
      font_addr <= 11'd0;
      font_data <= 8'd0;
      pal_wr    <= 1'b0;
      pal_addr  <= 4'd0;
      pal_data  <= 16'd0;
      err       <= 1'b0;
    end else begin
      opcode    <= opcode_d;
      arg_idx   <= arg_idx_d;
      b0        <= b0_d;
      b1        <= b1_d;
      tp        <= tp_d;
      fp        <= fp_d;
      fill_cnt  <= fill_cnt_d;
      fill_pat  <= fill_pat_d;
      text_wr   <= text_wr_d;
      text_addr <= text_addr_d;
      text_data <= text_data_d;
      font_wr   <= font_wr_d;
      font_addr <= font_addr_d;
      font_data <= font_data_d;
      pal_wr    <= pal_wr_d;
      pal_addr  <= pal_addr_d;
      pal_data  <= pal_data_d;
      err       <= err_d;
    end
  end

  assign bus.ovl_text_wr        = text_wr;
  assign bus.ovl_text_addr      = text_addr;
  assign bus.ovl_text_wrdata    = text_data;
  assign bus.ovl_font_wr        = font_wr;
  assign bus.ovl_font_addr      = font_addr;
  assign bus.ovl_font_wrdata    = font_data;
  assign bus.ovl_palette_wr     = pal_wr;
  assign bus.ovl_palette_addr   = pal_addr;
  assign bus.ovl_palette_wrdata = pal_data;

endmodule

// File: tb/tb_aqp_ovl_writer.sv
// Scoreboard bench for aqp_ovl_writer: expected writes are queued as commands are sent
// and matched, including their cycle of appearance, as the strobes come out.
module tb_aqp_ovl_writer;

  typedef struct {
    logic [1:0]  kind;   // 1 text, 2 font, 3 palette
    logic [10:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic ovl_clk = 1'b0;
  logic ovl_reset_n;
  logic busy, err;

  aqp_ovl_writer_if bus ();

  aqp_ovl_writer #(.FILL_WORDS(1024)) dut (
    .ovl_clk     (ovl_clk),
    .ovl_reset_n (ovl_reset_n),
    .bus         (bus),
    .busy        (busy),
    .err         (err)
  );

  always #5 ovl_clk = ~ovl_clk;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   low_cnt = 0;
  int   nstb;
  logic [1:0]  act_kind;
  logic [10:0] act_addr;
  logic [15:0] act_data;
  exp_t e;

  always @(posedge ovl_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [10:0] a, input logic [15:0] d,
                          input int c);
    exp_t x;
    x.kind = k; x.addr = a; x.data = d; x.cyc = c;
    q.push_back(x);
  endtask

  // Present a byte and return the cycle count right after the edge that took it.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    @(negedge ovl_clk);
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge ovl_clk);
      n++;
    end
    if (n >= 3000) check("ready_timeout", 1, 0);
    @(posedge ovl_clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic stall(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) @(posedge ovl_clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge ovl_clk) begin
    if (ovl_reset_n) begin
      nstb = int'(bus.ovl_text_wr) + int'(bus.ovl_font_wr) + int'(bus.ovl_palette_wr);
      if (nstb > 1) check("one_strobe", 64'(nstb), 1);
      if (!bus.cmd_ready) low_cnt++;
      if (nstb != 0) begin
        if (bus.ovl_text_wr) begin
          act_kind = 2'd1; act_addr = {1'b0, bus.ovl_text_addr}; act_data = bus.ovl_text_wrdata;
        end else if (bus.ovl_font_wr) begin
          act_kind = 2'd2; act_addr = bus.ovl_font_addr; act_data = {8'h00, bus.ovl_font_wrdata};
        end else begin
          act_kind = 2'd3; act_addr = {7'd0, bus.ovl_palette_addr};
          act_data = bus.ovl_palette_wrdata;
        end
        if (q.size() == 0) begin
          check("unexpected_strobe", {act_kind, act_addr, act_data}, 0);
        end else begin
          e = q.pop_front();
          check("write", {act_kind, act_addr, act_data}, {e.kind, e.addr, e.data});
          check("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int n;
    ovl_reset_n   = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge ovl_clk);
    ovl_reset_n = 1'b1;

    // Reset state.
    @(negedge ovl_clk);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {bus.ovl_text_wr, bus.ovl_font_wr, bus.ovl_palette_wr}, 0);
    check("rst_addrs", {bus.ovl_text_addr, bus.ovl_font_addr, bus.ovl_palette_addr}, 0);

    // Text writes back-to-back, with pointer wrap at 0x3FF.
    send_byte(8'h01, a);
    check("busy_in_arg", busy, 1);
    send_byte(8'hFF, a);
    send_byte(8'h03, a);
    send_byte(8'h02, a);
    send_byte(8'h41, a);
    send_byte(8'h1F, a); push_exp(2'd1, 11'h3FF, 16'h1F41, a);
    send_byte(8'h02, a);
    send_byte(8'h42, a);
    send_byte(8'h2F, a); push_exp(2'd1, 11'h000, 16'h2F42, a);
    stall(2);

    // Font writes with auto-increment, then a palette write.
    send_byte(8'h03, a);
    send_byte(8'hF8, a);
    send_byte(8'h07, a);
    send_byte(8'h04, a);
    send_byte(8'hAA, a); push_exp(2'd2, 11'h7F8, 16'h00AA, a);
    send_byte(8'h04, a);
    send_byte(8'h55, a); push_exp(2'd2, 11'h7F9, 16'h0055, a);
    send_byte(8'h05, a);
    send_byte(8'h13, a);
    send_byte(8'h34, a);
    send_byte(8'hF2, a); push_exp(2'd3, 11'h003, 16'hF234, a);
    stall(2);
    check("idle_busy", busy, 0);

    // Fill with stalls between bytes.
    low_cnt = 0;
    send_byte(8'h06, a); stall(5);
    send_byte(8'h20, a); stall(5);
    send_byte(8'h0F, a);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 1024; i++) push_exp(2'd1, 11'(i), 16'h0F20, a + i);
    n = 0;
    @(negedge ovl_clk);
    check("fill_busy", busy, 1);
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge ovl_clk);
      n++;
    end
    check("fill_end", bus.cmd_ready, 1);
    check("fill_ready_low", 64'(low_cnt), 1024);
    check("fill_sb_drained", 64'(q.size()), 0);
    send_byte(8'h02, a);
    send_byte(8'h41, a);
    send_byte(8'h00, a); push_exp(2'd1, 11'h000, 16'h0041, a);
    stall(3);

    // Abort a fill with reset at address 100.
    send_byte(8'h06, a);
    send_byte(8'hAA, a);
    send_byte(8'h55, a);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 1024; i++) push_exp(2'd1, 11'(i), 16'h55AA, a + i);
    n = 0;
    @(negedge ovl_clk);
    while (!(bus.ovl_text_wr && bus.ovl_text_addr == 10'd100) && n < 300) begin
      @(negedge ovl_clk);
      n++;
    end
    check("abort_reached_100", {bus.ovl_text_wr, bus.ovl_text_addr}, {1'b1, 10'd100});
    #1 ovl_reset_n = 1'b0;
    #1;
    check("abort_strobe_off", bus.ovl_text_wr, 0);
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_busy", busy, 0);
    q.delete();
    repeat (2) @(negedge ovl_clk);
    ovl_reset_n = 1'b1;
    send_byte(8'h02, a);
    send_byte(8'h58, a);
    send_byte(8'h00, a); push_exp(2'd1, 11'h000, 16'h0058, a);
    stall(2);

    // Unknown opcode: one err pulse, no strobe, next byte is an opcode.
    send_byte(8'h7E, a);
    bus.cmd_valid = 1'b0;
    @(negedge ovl_clk);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    @(negedge ovl_clk);
    check("err_one_cycle", err, 0);
    send_byte(8'h04, a);
    send_byte(8'hAA, a); push_exp(2'd2, 11'h000, 16'h00AA, a);
    stall(4);

    check("sb_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aqp_ovl_writer.md
Name: aqp_ovl_writer

Overview:
- Host-side command decoder that drives the write ports of the text overlay: text RAM, font RAM and palette.
- Consumes a byte-wide valid/ready command stream from the system controller link in the ovl_clk domain.
- Emits single-cycle registered write strobes with address and data, matching the overlay's write interface.
- Provides auto-incrementing text and font address pointers and a hardware text-fill engine for screen clears.

Parameters:
- FILL_WORDS, 1024: number of text words written by FILL_TEXT, starting at address 0. Must be at most 1024.

Ports:
- ovl_clk  in  1  clock.
- ovl_reset_n  in  1  asynchronous active-low reset.
- cmd_data  in  8  command/argument byte.
- cmd_valid  in  1  cmd_data is valid.
- cmd_ready  out  1  block accepts a byte; a byte transfers when cmd_valid && cmd_ready.
- busy  out  1  high while a command is partially received or a fill is running.
- err  out  1  one-cycle pulse when an unknown opcode is received.
- ovl_text_addr  out  10  text RAM write address.
- ovl_text_wrdata  out  16  text RAM write data: {color, char}.
- ovl_text_wr  out  1  text RAM write strobe.
- ovl_font_addr  out  11  font RAM write address.
- ovl_font_wrdata  out  8  font RAM write data.
- ovl_font_wr  out  1  font RAM write strobe.
- ovl_palette_addr  out  4  palette write index.
- ovl_palette_wrdata  out  16  palette entry: {a, r, g, b}, 4 bits each.
- ovl_palette_wr  out  1  palette write strobe.

Behaviour:
- Reset: every output is 0 except cmd_ready, which is 1. The text pointer (tp, 10 bits), font pointer (fp, 11 bits) and state are cleared. Reset asserted mid-command or mid-fill aborts it immediately; no further strobes are issued.
- States:
  - IDLE: the accepted byte is an opcode.
  - ARG: collecting argument bytes; a byte counter tracks the remaining count.
  - FILL: writing the fill pattern.
- Opcodes and arguments (multi-byte values are little-endian):
  - 0x01 SET_TP, 2 bytes: tp <= {b1[1:0], b0}.
  - 0x02 WR_TEXT, 2 bytes: write {b1, b0} at tp, then tp <= tp+1. Wraps 1023 -> 0.
  - 0x03 SET_FP, 2 bytes: fp <= {b1[2:0], b0}.
  - 0x04 WR_FONT, 1 byte: write b0 at fp, then fp <= fp+1. Wraps 2047 -> 0.
  - 0x05 WR_PAL, 3 bytes: write {b2, b1} at index b0[3:0]. No pointer is involved.
  - 0x06 FILL_TEXT, 2 bytes: enter FILL with pattern {b1, b0}.
  - Any other opcode: one-cycle err pulse in the cycle after acceptance; stay in IDLE.
- Unused argument high bits are ignored.
- Write latency: the strobe, address and data are registered and asserted in the cycle after the final argument byte is accepted. A strobe is high for exactly one cycle per write. Address and data outputs hold their last value after the strobe drops.
- Pointer increment occurs on the same clock edge the strobe is registered. A WR_TEXT that immediately follows SET_TP uses the new tp.
- The command stream may stall arbitrarily between bytes; no timeout applies. Back-to-back commands with no idle cycles are supported. cmd_ready stays 1 in IDLE and ARG, so a new opcode can be accepted in the same cycle the previous strobe is output.
- FILL:
  - cmd_ready = 0.
  - The engine issues FILL_WORDS consecutive ovl_text_wr cycles with addresses 0..FILL_WORDS-1 and the pattern as data. Writes start the cycle after the last argument is accepted.
  - After the last write, tp <= 0. The state returns to IDLE and cmd_ready = 1 in the following cycle.
  - Total cmd_ready-low time is FILL_WORDS cycles.
- busy = (state != IDLE).
- Text, font and palette strobes are never asserted in the same cycle.

Test Plan:
- Reset and idle: release reset with cmd_valid=0 -> all strobes 0, cmd_ready=1, busy=0, err=0.
- Text write with auto-increment: send 01 FF 03, 02 41 1F, 02 42 2F ->
  - ovl_text_wr pulses at addr 0x3FF with data 0x1F41;
  - then at addr 0x000 with data 0x2F42 (wrap);
  - each pulse one cycle after its last byte.
- Font and palette writes:
  - send 03 F8 07, 04 AA, 04 55 -> font writes 0x7F8=0xAA, 0x7F9=0x55;
  - send 05 13 34 F2 -> palette index 3 written with 0xF234.
- Fill with stalls:
  - send 06 20 0F with cmd_valid dropped for 5 cycles between bytes -> exactly 1024 text writes, addrs 0..1023, data 0x0F20, cmd_ready low for 1024 cycles;
  - then 02 41 00 writes addr 0.
- Abort and error:
  - assert reset mid-fill at addr 100 -> strobes stop immediately; post-reset 02 58 00 writes addr 0.
  - opcode 0x7E -> single err pulse, no strobe; the next byte is treated as an opcode.
